pc_fetch_ctrl: RTL

//  Fetch sequencer for the program counter. Drives the PC's advance enable, branch select
//  and branch offset, runs the instruction-memory request handshake and holds the fetched

---
 rtl/pc_fetch_ctrl_pkg.sv | 21 ++
 rtl/pc_fetch_timeout.sv | 35 +++
 rtl/pc_fetch_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared encodings and helpers for the PC fetch sequencer.
package pc_fetch_ctrl_pkg;

    // FSM encodings (kept as plain constants for older tools that read this block)
    localparam int         STATE_W = 3;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    // Sequential PC advance done by the PC block itself; the controller only enables it
    localparam int         PC_STEP       = 4;
    // Instruction alignment: redirect offsets must keep these bits clear
    localparam logic [1:0] MISALIGN_MASK = 2'b11;

    function automatic logic off_misaligned(input logic [1:0] off_lsb);
        return |(off_lsb & MISALIGN_MASK);
    endfunction

endpackage

// File: rtl/pc_fetch_timeout.sv
// Saturating fetch watchdog. expired_o fires combinationally on the cycle whose
// increment makes the count reach TIMEOUT_CYCLES, so the owner leaves for its fault
// state after exactly TIMEOUT_CYCLES counted cycles. TIMEOUT_CYCLES=0 disables it.
module pc_fetch_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = TIMEOUT_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W:0]   LIMIT   = TIMEOUT_CYCLES[CNT_W:0];

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   cnt_nxt;

    assign cnt_nxt   = {1'b0, cnt_q} + 1'b1;
    assign expired_o = (TIMEOUT_CYCLES != 0) && inc_i && (cnt_nxt >= LIMIT);

    // Count busy cycles, holding at the limit instead of wrapping
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC fetch sequencer: runs the imem request handshake, holds the fetched word for
// execute and pulses the PC enable exactly once per retired instruction.
// Optional: define PC_FETCH_CTRL_MISALIGN_TRAP_EN to trap redirects whose offset is
// not word aligned (PC left untouched, sticky misalign_o/err_o, controller parks in ERR).
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    output logic                  imem_req_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_off_i,
    output logic                  pc_en_o,
    output logic                  branch_en_o,
    output logic [DATA_WIDTH-1:0] branch_addr_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic                  misalign_o
);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [DATA_WIDTH-1:0] instr_q;
    logic                  retire, trap, capture;
    logic                  to_inc, to_exp;

    assign retire  = (state_q == ST_HOLD) && instr_ready_i;
    assign capture = ((state_q == ST_REQ) && imem_gnt_i && imem_rvalid_i) ||
                     ((state_q == ST_WAIT) && imem_rvalid_i);

`ifdef PC_FETCH_CTRL_MISALIGN_TRAP_EN
    logic misalign_q;

    assign trap       = retire && redirect_i && off_misaligned(redirect_off_i[1:0]);
    assign misalign_o = misalign_q;

    // Sticky misalign flag, cleared only by reset
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)  misalign_q <= 1'b0;
        else if (trap)  misalign_q <= 1'b1;
    end
`else
    assign trap       = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // PC controls are pure decodes of the retire cycle so the PC moves in that same cycle
    assign pc_en_o       = retire && !trap;
    assign branch_en_o   = pc_en_o && redirect_i;
    assign branch_addr_o = branch_en_o ? redirect_off_i : '0;

    assign imem_req_o    = (state_q == ST_REQ);
    assign instr_valid_o = (state_q == ST_HOLD);
    assign instr_o       = instr_q;
    assign busy_o        = (state_q != ST_IDLE);
    // ERR is only left through reset, so the state decode is already sticky
    assign err_o         = (state_q == ST_ERR);

    // Watchdog runs only while a fetch is outstanding; held clear otherwise so it
    // starts from zero on every entry to REQ
    assign to_inc = (state_q == ST_REQ) || (state_q == ST_WAIT);

    pc_fetch_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .clr_i     (!to_inc),
        .inc_i     (to_inc),
        .expired_o (to_exp)
    );

    // Next-state logic; arriving data wins over a watchdog expiring in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_REQ;
            ST_REQ: begin
                if (imem_gnt_i && imem_rvalid_i) state_d = ST_HOLD;
                else if (to_exp)                 state_d = ST_ERR;
                else if (imem_gnt_i)             state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid_i) state_d = ST_HOLD;
                else if (to_exp)   state_d = ST_ERR;
            end
            ST_HOLD: begin
                if (trap)        state_d = ST_ERR;
                else if (retire) state_d = start_i ? ST_REQ : ST_IDLE;
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // Instruction hold register, loaded only when the fetch completes
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)    instr_q <= '0;
        else if (capture) instr_q <= imem_rdata_i;
    end

endmodule
